// File: rtl/timer16x2.sv
// Two-channel 16-bit I/O-mapped timer/counter with terminal-count pulses and optional auto-reload.
// Define TIMER16X2_IRQ_EN to add a registered irq output (done0 | done1).
module timer16x2 #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cs,
  input  logic             iowrite,
  input  logic             ioread,
  input  logic [3:0]       addr,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] rdata,
  input  logic             pulse0,
  input  logic             pulse1,
  output logic             cout0,
  output logic             cout1
`ifdef TIMER16X2_IRQ_EN
  ,
  output logic             irq
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q [2];
  state_e           state_d [2];
  logic [1:0]       mode_q  [2];
  logic [1:0]       mode_d  [2];
  logic [CNT_W-1:0] init_q  [2];
  logic [CNT_W-1:0] init_d  [2];
  logic [CNT_W-1:0] count_q [2];
  logic [CNT_W-1:0] count_d [2];
  logic [2:0]       sync_q  [2];
  logic [1:0]       done_q, done_d, cout_q, cout_d;
  logic [1:0]       run, tick, edge_det, mode_wr, init_wr, stat_rd, pulse_in;

  assign pulse_in = {pulse1, pulse0};
  assign cout0    = cout_q[0];
  assign cout1    = cout_q[1];

  // Channel n owns offsets MODE 0x0+2n, STATUS 0x4+2n, INIT/COUNT 0x8+2n.
  always_comb begin
    mode_wr  = '0;
    init_wr  = '0;
    stat_rd  = '0;
    edge_det = '0;
    tick     = '0;
    run      = '0;
    for (int n = 0; n < 2; n++) begin
      mode_wr[n]  = cs & iowrite & (addr == 4'(2 * n));
      stat_rd[n]  = cs & ioread & (addr == 4'(4 + 2 * n));
      init_wr[n]  = cs & iowrite & (addr == 4'(8 + 2 * n));
      edge_det[n] = sync_q[n][1] & ~sync_q[n][2];
      tick[n]     = mode_q[n][0] ? edge_det[n] : 1'b1;
      // The reload cycle of a repeating channel still counts as running.
      run[n]      = (state_q[n] == StRun) || ((state_q[n] == StDone) && mode_q[n][1]);
    end
  end

  always_comb begin
    done_d = done_q;
    cout_d = '0;
    for (int n = 0; n < 2; n++) begin
      state_d[n] = state_q[n];
      mode_d[n]  = mode_q[n];
      init_d[n]  = init_q[n];
      count_d[n] = count_q[n];
      if (stat_rd[n]) begin
        done_d[n] = 1'b0;
      end
      if (mode_wr[n]) begin
        mode_d[n]  = wdata[1:0];
        done_d[n]  = 1'b0;
        state_d[n] = StIdle;
      end else if (init_wr[n]) begin
        // A write wins over a coincident tick.
        init_d[n]  = wdata;
        count_d[n] = wdata;
        done_d[n]  = 1'b0;
        state_d[n] = (wdata != '0) ? StRun : StIdle;
      end else begin
        unique case (state_q[n])
          StRun: begin
            if (tick[n]) begin
              if (count_q[n] == CNT_W'(1)) begin
                count_d[n] = '0;
                done_d[n]  = 1'b1;
                cout_d[n]  = 1'b1;
                state_d[n] = StDone;
              end else begin
                count_d[n] = count_q[n] - CNT_W'(1);
              end
            end
          end
          StDone: begin
            if (mode_q[n][1]) begin
              count_d[n] = init_q[n];
              state_d[n] = StRun;
            end else begin
              state_d[n] = StIdle;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < 2; n++) begin
        state_q[n] <= StIdle;
        mode_q[n]  <= '0;
        init_q[n]  <= '0;
        count_q[n] <= '0;
        sync_q[n]  <= '0;
      end
      done_q <= '0;
      cout_q <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        state_q[n] <= state_d[n];
        mode_q[n]  <= mode_d[n];
        init_q[n]  <= init_d[n];
        count_q[n] <= count_d[n];
        sync_q[n]  <= {sync_q[n][1:0], pulse_in[n]};
      end
      done_q <= done_d;
      cout_q <= cout_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (cs & ioread) begin
      case (addr)
        4'h4:    rdata[CNT_W-1 -: 2] = {done_q[0], run[0]};
        4'h6:    rdata[CNT_W-1 -: 2] = {done_q[1], run[1]};
        4'h8:    rdata = count_q[0];
        4'hA:    rdata = count_q[1];
        default: rdata = '0;
      endcase
    end
  end

`ifdef TIMER16X2_IRQ_EN
  logic irq_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |done_q;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_timer16x2.sv
// Scoreboard bench for timer16x2: expected cout cycles and read data are queued at stimulus time.
module tb_timer16x2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0;
  logic        iowrite = 1'b0;
  logic        ioread = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        pulse0 = 1'b0;
  logic        pulse1 = 1'b0;
  logic        cout0, cout1;
`ifdef TIMER16X2_IRQ_EN
  logic        irq;
`endif

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp0_q[$];
  int          exp1_q[$];
  logic [15:0] rd_q[$];
  int          c0, c1, p2;

  timer16x2 #(.CNT_W(16)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .cs     (cs),
    .iowrite(iowrite),
    .ioread (ioread),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .pulse0 (pulse0),
    .pulse1 (pulse1),
    .cout0  (cout0),
    .cout1  (cout1)
`ifdef TIMER16X2_IRQ_EN
    ,
    .irq    (irq)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every cout pulse must match the oldest pending expected cycle.
  always @(negedge clock) begin
    if (cout0 === 1'b1) begin
      if (exp0_q.size() > 0) check("cout0_cycle", cyc, exp0_q.pop_front());
      else check("cout0_unexpected", 1, 0);
    end
    if (cout1 === 1'b1) begin
      if (exp1_q.size() > 0) check("cout1_cycle", cyc, exp1_q.pop_front());
      else check("cout1_unexpected", 1, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    cs = 1'b1; iowrite = 1'b1; addr = a; wdata = d;
    @(posedge clock);
    #1;
    cs = 1'b0; iowrite = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [15:0] e);
    logic [15:0] got;
    rd_q.push_back(e);
    cs = 1'b1; ioread = 1'b1; addr = a;
    @(negedge clock);
    got = rdata;
    check(tag, {16'h0, got}, {16'h0, rd_q.pop_front()});
    @(posedge clock);
    #1;
    cs = 1'b0; ioread = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(3);
    reset_n = 1'b1;
    tick(2);
    rd("rst_status0", 4'h4, 16'h0000);
    rd("rst_count0",  4'h8, 16'h0000);
    rd("rst_status1", 4'h6, 16'h0000);
    rd("rst_count1",  4'hA, 16'h0000);

    // Timer single-shot
    wr(4'h0, 16'h0000);
    wr(4'h8, 16'd5);
    c0 = cyc;
    exp0_q.push_back(c0 + 5);
    rd("ss_count_load", 4'h8, 16'd5);
    rd("ss_status_run", 4'h4, 16'h4000);
    tick(8);
    rd("ss_count_end",  4'h8, 16'h0000);
    rd("ss_status_end", 4'h4, 16'h8000);
    rd("ss_status_clr", 4'h4, 16'h0000);
    rd("mode_read",     4'h0, 16'h0000);

    // Timer repeat on channel 1
    wr(4'h2, 16'h0002);
    wr(4'hA, 16'd3);
    c1 = cyc;
    for (int k = 0; k < 11; k++) exp1_q.push_back(c1 + 3 + 4 * k);
    tick(18);
    rd("rep_status", 4'h6, 16'hC000);
    while (cyc < c1 + 44) tick(1);
    wr(4'h2, 16'h0000);
    rd("rep_stopped", 4'h6, 16'h0000);

    // Counter mode on channel 0
    wr(4'h0, 16'h0001);
    wr(4'h8, 16'd2);
    pulse0 = 1'b1;
    tick(3);
    pulse0 = 1'b0;
    tick(3);
    rd("cnt_once", 4'h8, 16'd1);
    pulse0 = 1'b1;
    p2 = cyc;
    exp0_q.push_back(p2 + 3);
    tick(3);
    pulse0 = 1'b0;
    tick(6);

    // STATUS read coinciding with terminal count
    wr(4'h0, 16'h0000);
    wr(4'h8, 16'd4);
    c0 = cyc;
    exp0_q.push_back(c0 + 4);
    tick(3);
    rd("col_rd_term", 4'h4, 16'h4000);
    rd("col_done_kept", 4'h4, 16'h8000);
    rd("col_done_clr", 4'h4, 16'h0000);

    // INIT write coinciding with a tick
    wr(4'h8, 16'd10);
    c0 = cyc;
    tick(2);
    wr(4'h8, 16'd9);
    exp0_q.push_back(c0 + 3 + 9);
    rd("col_init_wins", 4'h8, 16'd9);
    tick(12);

    // INIT of zero stays idle
    wr(4'h8, 16'd0);
    tick(8);
    rd("zero_status", 4'h4, 16'h0000);
    rd("zero_count",  4'h8, 16'h0000);

`ifdef TIMER16X2_IRQ_EN
    wr(4'h8, 16'd2);
    c0 = cyc;
    exp0_q.push_back(c0 + 2);
    tick(2);
    check("irq_lag", {31'h0, irq}, 32'h0);
    tick(1);
    check("irq_rise", {31'h0, irq}, 32'h1);
    rd("irq_status", 4'h4, 16'h8000);
    tick(1);
    check("irq_fall", {31'h0, irq}, 32'h0);
`endif

    // Reset mid-count
    wr(4'h8, 16'd100);
    tick(49);
    reset_n = 1'b0;
    rd("mid_rst_count0",  4'h8, 16'h0000);
    rd("mid_rst_status0", 4'h4, 16'h0000);
    rd("mid_rst_count1",  4'hA, 16'h0000);
    rd("mid_rst_status1", 4'h6, 16'h0000);
    reset_n = 1'b1;
    rd("post_rst_count0", 4'h8, 16'h0000);
    tick(200);

    // Write with cs low is ignored
    cs = 1'b0; iowrite = 1'b1; addr = 4'h8; wdata = 16'd3;
    tick(1);
    iowrite = 1'b0;
    tick(5);
    rd("cs_low_ignored", 4'h8, 16'h0000);

    check("cout0_missing", exp0_q.size(), 0);
    check("cout1_missing", exp1_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
